// File: rtl/dm_bus_arbiter.sv
// Two-master sequencing arbiter for the P8 single-port data-memory bus.
// Define ARB_CPU_PRIO_EN for fixed CPU priority on ties; round-robin otherwise.
module dm_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_kill,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_byteen,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        aux_req,
  input  logic [31:0] aux_addr,
  input  logic [3:0]  aux_byteen,
  input  logic [31:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_done,
  output logic [31:0] aux_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DONE} stateT;
  typedef enum logic {OWN_CPU, OWN_AUX} ownerT;

  localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES - 1);

  stateT       state, nextState;
  ownerT       owner;
  logic [29:0] latAddr;
  logic [3:0]  latByteen;
  logic [31:0] latWdata;
  logic [3:0]  waitCnt;
  logic [31:0] cpuRdataQ, auxRdataQ;
  logic        cpuElig, cpuTieWin, cpuWins, auxWins;
  logic        unusedAddrBits;

  // Memory is word-addressed; byte offset is carried by the byte enables.
  assign unusedAddrBits = ^{cpu_addr[1:0], aux_addr[1:0]};

  assign cpuElig = cpu_req & ~cpu_kill;

`ifdef ARB_CPU_PRIO_EN
  assign cpuTieWin = 1'b1;
`else
  ownerT lastOwner;
  assign cpuTieWin = ~aux_req | (lastOwner == OWN_AUX);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    cpuWins   = 1'b0;
    auxWins   = 1'b0;
    unique case (state)
      IDLE: begin
        cpuWins = cpuElig & cpuTieWin;
        auxWins = aux_req & ~cpuWins;
        if (cpuWins | auxWins) nextState = ISSUE;
      end
      ISSUE: nextState = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:  if (waitCnt == WaitLast) nextState = RESP;
      RESP:  nextState = DONE;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_CPU;
      latAddr   <= '0;
      latByteen <= '0;
      latWdata  <= '0;
      waitCnt   <= '0;
      cpuRdataQ <= '0;
      auxRdataQ <= '0;
`ifndef ARB_CPU_PRIO_EN
      lastOwner <= OWN_AUX;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (cpuWins) begin
            owner     <= OWN_CPU;
            latAddr   <= cpu_addr[31:2];
            latByteen <= cpu_byteen;
            latWdata  <= cpu_wdata;
          end else if (auxWins) begin
            owner     <= OWN_AUX;
            latAddr   <= aux_addr[31:2];
            latByteen <= aux_byteen;
            latWdata  <= aux_wdata;
          end
        end
        ISSUE: waitCnt <= '0;
        WAIT:  waitCnt <= waitCnt + 4'd1;
        RESP: begin
          // Stores leave both read-holding registers untouched.
          if (latByteen == '0) begin
            if (owner == OWN_AUX) auxRdataQ <= mem_rdata;
            else                  cpuRdataQ <= mem_rdata;
          end
        end
        DONE: begin
`ifndef ARB_CPU_PRIO_EN
          lastOwner <= owner;
`endif
        end
        default: ;
      endcase
    end
  end

  assign mem_en     = (state == ISSUE);
  assign mem_addr   = {latAddr, 2'b00};
  assign mem_byteen = latByteen;
  assign mem_wdata  = latWdata;
  assign cpu_rdata  = cpuRdataQ;
  assign aux_rdata  = auxRdataQ;
  assign aux_gnt    = (state == IDLE) & auxWins;
  assign aux_done   = (state == DONE) & (owner == OWN_AUX);
  assign cpu_stall  = cpu_req & ~cpu_kill & ~((state == DONE) & (owner == OWN_CPU));

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Scoreboard bench for dm_bus_arbiter: stimulus queues expected memory
// strobes, grants and completions; a negedge monitor pops and compares them.
module tb_dm_bus_arbiter;
  localparam int unsigned W = 1;

  logic        clk, reset;
  logic        cpu_req, cpu_kill, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_byteen;
  logic        aux_req, aux_gnt, aux_done;
  logic [31:0] aux_addr, aux_wdata, aux_rdata;
  logic [3:0]  aux_byteen;
  logic        mem_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;

  dm_bus_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_kill(cpu_kill), .cpu_addr(cpu_addr),
    .cpu_byteen(cpu_byteen), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_byteen(aux_byteen),
    .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_done(aux_done),
    .aux_rdata(aux_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Fixed-latency memory: data appears only in the cycle W+1 after the strobe.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0104) return 32'hDEAD_BEEF;
    return a ^ 32'hC0DE_0000;
  endfunction

  logic [W:0]  pipe = '0;
  logic [31:0] rdAddr = '0;
  always @(posedge clk) begin
    pipe <= {pipe[W-1:0], mem_en};
    if (mem_en) rdAddr <= mem_addr;
  end
  assign mem_rdata = pipe[W] ? memWord(rdAddr) : 32'h5A5A_5A5A;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int unsigned cyc;
  } memExpT;
  typedef struct {
    logic        isAux;
    logic [31:0] rd;
    int unsigned cyc;
  } doneExpT;

  memExpT      memQ[$];
  doneExpT     doneQ[$];
  int unsigned gntQ[$];

  memExpT      m;
  doneExpT     d;
  int unsigned g;
  logic        prevMemEn = 1'b0;

  always @(negedge clk) begin
    if (mem_en) begin
      chk("mem_en single pulse", {31'b0, prevMemEn}, 32'd0);
      if (memQ.size() == 0) chk("unexpected mem_en", {31'b0, mem_en}, 32'd0);
      else begin
        m = memQ.pop_front();
        chk("mem_addr", mem_addr, m.addr);
        chk("mem_byteen", {28'b0, mem_byteen}, {28'b0, m.be});
        chk("mem_wdata", mem_wdata, m.wd);
        chk("mem_en cycle", cyc, m.cyc);
      end
    end
    if (cpu_req && !cpu_kill && !cpu_stall) begin
      if (doneQ.size() == 0) chk("unexpected cpu completion", {31'b0, cpu_stall}, 32'd1);
      else begin
        d = doneQ.pop_front();
        chk("owner is cpu", {31'b0, d.isAux}, 32'd0);
        chk("cpu_rdata", cpu_rdata, d.rd);
        chk("cpu done cycle", cyc, d.cyc);
      end
    end
    if (aux_done) begin
      if (doneQ.size() == 0) chk("unexpected aux_done", {31'b0, aux_done}, 32'd0);
      else begin
        d = doneQ.pop_front();
        chk("owner is aux", {31'b0, d.isAux}, 32'd1);
        chk("aux_rdata", aux_rdata, d.rd);
        chk("aux done cycle", cyc, d.cyc);
      end
    end
    if (aux_gnt) begin
      if (gntQ.size() == 0) chk("unexpected aux_gnt", {31'b0, aux_gnt}, 32'd0);
      else begin
        g = gntQ.pop_front();
        chk("aux_gnt cycle", cyc, g);
      end
    end
    prevMemEn <= mem_en;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, " cpu_rdata"}, cpu_rdata, 32'd0);
    chk({tag, " aux_rdata"}, aux_rdata, 32'd0);
    chk({tag, " mem_en"}, {31'b0, mem_en}, 32'd0);
    chk({tag, " mem_addr"}, mem_addr, 32'd0);
    chk({tag, " mem_byteen"}, {28'b0, mem_byteen}, 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " aux_gnt"}, {31'b0, aux_gnt}, 32'd0);
    chk({tag, " aux_done"}, {31'b0, aux_done}, 32'd0);
    chk({tag, " cpu_stall"}, {31'b0, cpu_stall}, 32'd0);
  endtask

  // Uncontended CPU access: stall must hold for 3+W cycles then drop in DONE.
  task automatic cpuAccess(input logic [31:0] addr, input logic [31:0] memAddr,
                           input logic [3:0] be, input logic [31:0] wd,
                           input logic [31:0] expRd);
    cpu_addr = addr; cpu_byteen = be; cpu_wdata = wd; cpu_req = 1'b1;
    memQ.push_back('{memAddr, be, wd, cyc + 1});
    doneQ.push_back('{1'b0, expRd, cyc + 3 + W});
    for (int i = 0; i <= 3 + W; i++) begin
      @(negedge clk);
      chk("cpu_stall window", {31'b0, cpu_stall}, (i < 3 + W) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  int unsigned s;

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_kill = 0; cpu_addr = 0; cpu_byteen = 0; cpu_wdata = 0;
    aux_req = 0; aux_addr = 0; aux_byteen = 0; aux_wdata = 0;
    tick(2);
    @(negedge clk);
    checkAllZero("reset");
    tick(1);
    reset = 1'b0;
    tick(1);

    cpuAccess(32'h0000_0104, 32'h0000_0104, 4'b0000, 32'h0, 32'hDEAD_BEEF);
    cpuAccess(32'h0000_1002, 32'h0000_1000, 4'b0100, 32'h00AB_0000, 32'hDEAD_BEEF);

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);

    // Both masters held for three back-to-back accesses (period 4+W).
    s = cyc;
    cpu_addr = 32'h200; cpu_byteen = 4'b0000; cpu_wdata = 32'h1111_1111; cpu_req = 1'b1;
    aux_addr = 32'h304; aux_byteen = 4'b0000; aux_wdata = 32'h2222_2222; aux_req = 1'b1;
    memQ.push_back('{32'h200, 4'b0000, 32'h1111_1111, s + 1});
    doneQ.push_back('{1'b0, 32'hC0DE_0200, s + 4});
`ifdef ARB_CPU_PRIO_EN
    memQ.push_back('{32'h200, 4'b0000, 32'h1111_1111, s + 6});
    doneQ.push_back('{1'b0, 32'hC0DE_0200, s + 9});
`else
    gntQ.push_back(s + 5);
    memQ.push_back('{32'h304, 4'b0000, 32'h2222_2222, s + 6});
    doneQ.push_back('{1'b1, 32'hC0DE_0304, s + 9});
`endif
    memQ.push_back('{32'h200, 4'b0000, 32'h1111_1111, s + 11});
    doneQ.push_back('{1'b0, 32'hC0DE_0200, s + 14});
    tick(15);
    cpu_req = 1'b0; aux_req = 1'b0;
    tick(2);

    // Killed request in IDLE: never issued, no stall.
    cpu_addr = 32'h400; cpu_req = 1'b1; cpu_kill = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("killed cpu_stall", {31'b0, cpu_stall}, 32'd0);
      chk("killed mem_en", {31'b0, mem_en}, 32'd0);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_kill = 1'b0;
    tick(2);

    // Kill during WAIT: store still completes, cpu_rdata untouched.
    s = cyc;
    cpu_addr = 32'h2008; cpu_byteen = 4'b1111; cpu_wdata = 32'h1234_5678; cpu_req = 1'b1;
    memQ.push_back('{32'h2008, 4'b1111, 32'h1234_5678, s + 1});
    doneQ.push_back('{1'b0, 32'hC0DE_0200, s + 4});
    tick(2);
    cpu_kill = 1'b1;
    tick(1);
    cpu_kill = 1'b0;
    tick(2);
    cpu_req = 1'b0;
    tick(2);

    // Reset during WAIT of an aux read: access abandoned, no aux_done.
    s = cyc;
    aux_addr = 32'h304; aux_byteen = 4'b0000; aux_wdata = 32'h3333_3333; aux_req = 1'b1;
    gntQ.push_back(s);
    memQ.push_back('{32'h304, 4'b0000, 32'h3333_3333, s + 1});
    tick(1);
    aux_req = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    checkAllZero("mid reset");
    tick(1);
    reset = 1'b0;
    tick(8);

    cpuAccess(32'h0000_0104, 32'h0000_0104, 4'b0000, 32'h0, 32'hDEAD_BEEF);
    tick(3);

    chk("mem expectations left", memQ.size(), 32'd0);
    chk("done expectations left", doneQ.size(), 32'd0);
    chk("grant expectations left", gntQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
